al4s3b_wb_initiator: RTL and testbench



---
 rtl/al4s3b_wb_initiator_pkg.sv | 15 +
 rtl/al4s3b_wb_initiator.sv | 168 ++++++++++++++++
 tb/tb_al4s3b_wb_initiator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/al4s3b_wb_initiator_pkg.sv
// Shared types and default constants for the AL4S3B fabric Wishbone initiator.
// State encoding plus the default timeout geometry and error read value.
package al4s3b_wb_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } wb_state_e;

    localparam int          TIMEOUT_CNTR_WIDTH_DEF = 4;
    localparam int          TIMEOUT_CYCLES_DEF     = 15;
    localparam logic [31:0] TIMEOUT_READ_VALUE_DEF = 32'hBAD_FAB_AC;

endpackage

// File: rtl/al4s3b_wb_initiator.sv
// Single-outstanding Wishbone initiator: a valid/ready command port drives one
// classic WBs_* cycle, and the result (or a timeout error) is returned on a response port.
module al4s3b_wb_initiator
    import al4s3b_wb_initiator_pkg::*;
#(
    parameter int                ADDRWIDTH          = 17,
    parameter int                DATAWIDTH          = 32,
    parameter int                TIMEOUT_CNTR_WIDTH = TIMEOUT_CNTR_WIDTH_DEF,
    parameter int                TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF,
    parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = TIMEOUT_READ_VALUE_DEF
) (
    input  logic                     WBs_CLK_i,
    input  logic                     WBs_RST_i,

    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [ADDRWIDTH-1:0]     cmd_adr_i,
    input  logic [(DATAWIDTH/8)-1:0] cmd_byte_stb_i,
    input  logic [DATAWIDTH-1:0]     cmd_dat_i,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATAWIDTH-1:0]     rsp_dat_o,
    output logic                     rsp_err_o,

    output logic [ADDRWIDTH-1:0]     WBs_ADR_o,
    output logic                     WBs_CYC_o,
    output logic                     WBs_STB_o,
    output logic                     WBs_WE_o,
    output logic                     WBs_RD_o,
    output logic [(DATAWIDTH/8)-1:0] WBs_BYTE_STB_o,
    output logic [DATAWIDTH-1:0]     WBs_WR_DAT_o,
    input  logic [DATAWIDTH-1:0]     WBs_RD_DAT_i,
    input  logic                     WBs_ACK_i,

    output logic                     busy_o
);

    localparam int STBW = DATAWIDTH / 8;

    // Word-aligned bus address: the two byte-offset bits are always driven low.
    localparam logic [ADDRWIDTH-1:0] ADR_MASK =
        ~{{(ADDRWIDTH-2){1'b0}}, 2'b11};
    localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_LAST =
        TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_ONE =
        TIMEOUT_CNTR_WIDTH'(1);

    wb_state_e                     state_q, state_d;
    logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]          adr_q, adr_d;
    logic                          cyc_q, cyc_d;
    logic                          we_q, we_d;
    logic                          rd_q, rd_d;
    logic [STBW-1:0]               byte_stb_q, byte_stb_d;
    logic [DATAWIDTH-1:0]          wr_dat_q, wr_dat_d;
    logic [DATAWIDTH-1:0]          rsp_dat_q, rsp_dat_d;
    logic                          rsp_err_q, rsp_err_d;

    // Next-state, timeout counter and bus/response register updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        rd_d       = rd_q;
        byte_stb_d = byte_stb_q;
        wr_dat_d   = wr_dat_q;
        rsp_dat_d  = rsp_dat_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    adr_d      = cmd_adr_i & ADR_MASK;
                    we_d       = cmd_we_i;
                    rd_d       = ~cmd_we_i;
                    cyc_d      = 1'b1;
                    byte_stb_d = cmd_byte_stb_i;
                    wr_dat_d   = cmd_dat_i;
                    cnt_d      = '0;
                    state_d    = ST_BUS;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BUS: begin
                // ACK is checked first so it beats a same-cycle terminal count.
                if (WBs_ACK_i) begin
                    rsp_dat_d = we_q ? '0 : WBs_RD_DAT_i;
                    rsp_err_d = 1'b0;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    rd_d      = 1'b0;
                    state_d   = ST_RSP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_dat_d = TIMEOUT_READ_VALUE;
                    rsp_err_d = 1'b1;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    rd_d      = 1'b0;
                    state_d   = ST_RSP;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    state_d   = ST_BUS;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                rd_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            byte_stb_q <= '0;
            wr_dat_q   <= '0;
            rsp_dat_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            byte_stb_q <= byte_stb_d;
            wr_dat_q   <= wr_dat_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Ready is masked during reset so no command is taken while it is held.
    assign cmd_ready_o    = (state_q == ST_IDLE) & ~WBs_RST_i;
    assign rsp_valid_o    = (state_q == ST_RSP);
    assign busy_o         = (state_q != ST_IDLE);
    assign rsp_dat_o      = rsp_dat_q;
    assign rsp_err_o      = rsp_err_q;

    assign WBs_ADR_o      = adr_q;
    assign WBs_CYC_o      = cyc_q;
    assign WBs_STB_o      = cyc_q;
    assign WBs_WE_o       = we_q;
    assign WBs_RD_o       = rd_q;
    assign WBs_BYTE_STB_o = byte_stb_q;
    assign WBs_WR_DAT_o   = wr_dat_q;

endmodule

// File: tb/tb_al4s3b_wb_initiator.sv
// Scoreboard bench for al4s3b_wb_initiator: expected responses are queued at
// command accept and compared when the response handshake happens.
module tb_al4s3b_wb_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [16:0] cmd_adr_i = 17'h0;
    logic [3:0]  cmd_byte_stb_i = 4'h0;
    logic [31:0] cmd_dat_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [16:0] WBs_ADR_o;
    logic        WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o;
    logic [3:0]  WBs_BYTE_STB_o;
    logic [31:0] WBs_WR_DAT_o;
    logic [31:0] WBs_RD_DAT_i = 32'h0;
    logic        WBs_ACK_i = 1'b0;
    logic        busy_o;

    al4s3b_wb_initiator dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_adr_i      (cmd_adr_i),
        .cmd_byte_stb_i (cmd_byte_stb_i),
        .cmd_dat_i      (cmd_dat_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_dat_o      (rsp_dat_o),
        .rsp_err_o      (rsp_err_o),
        .WBs_ADR_o      (WBs_ADR_o),
        .WBs_CYC_o      (WBs_CYC_o),
        .WBs_STB_o      (WBs_STB_o),
        .WBs_WE_o       (WBs_WE_o),
        .WBs_RD_o       (WBs_RD_o),
        .WBs_BYTE_STB_o (WBs_BYTE_STB_o),
        .WBs_WR_DAT_o   (WBs_WR_DAT_o),
        .WBs_RD_DAT_i   (WBs_RD_DAT_i),
        .WBs_ACK_i      (WBs_ACK_i),
        .busy_o         (busy_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_at  = 0;
    logic [31:0] rd_word = 32'h0;
    int          bus_cnt = 0;
    int          cyc_cnt = 0;
    int          we_cnt  = 0;
    int          rd_cnt  = 0;
    int          lat     = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Client model: acks on bus cycle ack_at (0 = never) and tallies bus activity.
    initial forever begin
        @(negedge clk);
        if (WBs_CYC_o && WBs_STB_o) begin
            bus_cnt++;
            cyc_cnt++;
            if (WBs_WE_o) we_cnt++;
            if (WBs_RD_o) rd_cnt++;
            WBs_ACK_i    = (ack_at != 0) && (bus_cnt == ack_at);
            WBs_RD_DAT_i = rd_word;
        end else begin
            bus_cnt      = 0;
            WBs_ACK_i    = 1'b0;
            WBs_RD_DAT_i = 32'h0;
        end
    end

    task automatic issue(input logic we, input logic [16:0] adr, input logic [3:0] stb,
                         input logic [31:0] wd, input logic [31:0] exp_dat, input logic exp_err);
        bit ok = 1'b0;
        cmd_valid_i    = 1'b1;
        cmd_we_i       = we;
        cmd_adr_i      = adr;
        cmd_byte_stb_i = stb;
        cmd_dat_i      = wd;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("cmd_accept", ok, 1);
        if (ok) sb_q.push_back({exp_dat, exp_err});
        cyc_cnt = 0;
        we_cnt  = 0;
        rd_cnt  = 0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        lat = 1;
        if (ok) begin
            check_eq("bus_ctrl", {WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o, busy_o},
                     {1'b1, 1'b1, we, ~we, 1'b1});
            check_eq("bus_adr", WBs_ADR_o, adr & 17'h1FFFC);
            check_eq("bus_stb", WBs_BYTE_STB_o, stb);
            check_eq("bus_wdat", WBs_WR_DAT_o, wd);
        end
    endtask

    task automatic get_rsp(input int hold, input int exp_lat);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check_eq("rsp_seen", seen, 1);
        check_eq("sb_depth", sb_q.size(), 1);
        if (seen && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (exp_lat != 0) check_eq("rsp_latency", lat, exp_lat);
            check_eq("rsp_dat", rsp_dat_o, e.dat);
            check_eq("rsp_err", rsp_err_o, e.err);
            check_eq("rsp_bus_idle", {WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o}, 4'b0000);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("rsp_hold", {rsp_valid_o, cmd_ready_o, rsp_err_o, rsp_dat_o},
                         {1'b1, 1'b0, e.err, e.dat});
            end
            rsp_ready_i = 1'b1;
            @(negedge clk);
            rsp_ready_i = 1'b0;
            check_eq("post_rsp", {rsp_valid_o, cmd_ready_o, busy_o}, 3'b010);
        end
    endtask

    initial begin
        bit vflag;
        repeat (3) @(negedge clk);
        check_eq("rst_bus", {WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o, WBs_ADR_o, WBs_BYTE_STB_o}, 64'h0);
        check_eq("rst_rsp", {rsp_valid_o, rsp_err_o, busy_o, cmd_ready_o, rsp_dat_o}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", cmd_ready_o, 1);

        // Write, acked on the third bus cycle.
        ack_at = 3;
        issue(1'b1, 17'h00008, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        get_rsp(0, 4);
        check_eq("wr_cyc_cycles", cyc_cnt, 3);
        check_eq("wr_we_cycles", we_cnt, 3);
        check_eq("wr_rd_cycles", rd_cnt, 0);

        // Read with immediate ACK; unaligned address low bits get dropped.
        ack_at  = 1;
        rd_word = 32'h1234_5678;
        issue(1'b0, 17'h0000B, 4'h3, 32'h0, 32'h1234_5678, 1'b0);
        get_rsp(0, 2);
        check_eq("rd_rd_cycles", rd_cnt, 1);
        check_eq("rd_we_cycles", we_cnt, 0);

        // Read with no ACK: timeout after exactly 15 bus cycles.
        ack_at = 0;
        issue(1'b0, 17'h00004, 4'hF, 32'h0, 32'hBAD_FAB_AC, 1'b1);
        get_rsp(0, 16);
        check_eq("to_cyc_cycles", cyc_cnt, 15);

        // ACK on the 15th bus cycle beats the terminal count.
        ack_at  = 15;
        rd_word = 32'hCAFE_0015;
        issue(1'b0, 17'h00010, 4'hF, 32'h0, 32'hCAFE_0015, 1'b0);
        get_rsp(0, 16);
        check_eq("ack15_cyc_cycles", cyc_cnt, 15);

        // Response back-pressured 5 cycles while a new command waits.
        ack_at  = 1;
        rd_word = 32'h0BAD_BEEF;
        issue(1'b0, 17'h00020, 4'hF, 32'h0, 32'h0BAD_BEEF, 1'b0);
        cmd_valid_i    = 1'b1;
        cmd_we_i       = 1'b1;
        cmd_adr_i      = 17'h0000C;
        cmd_byte_stb_i = 4'h5;
        cmd_dat_i      = 32'hA5A5_5A5A;
        ack_at = 2;
        get_rsp(5, 2);
        issue(1'b1, 17'h0000C, 4'h5, 32'hA5A5_5A5A, 32'h0, 1'b0);
        get_rsp(0, 3);

        // Reset mid-BUS drops the transaction.
        ack_at = 0;
        issue(1'b0, 17'h00004, 4'hF, 32'h0, 32'hBAD_FAB_AC, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_bus", {WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o, WBs_ADR_o, WBs_BYTE_STB_o}, 64'h0);
        check_eq("mid_rst_rsp", {rsp_valid_o, rsp_err_o, busy_o, cmd_ready_o, rsp_dat_o}, 64'h0);
        check_eq("mid_rst_wdat", WBs_WR_DAT_o, 32'h0);
        rst = 1'b0;
        sb_q.delete();
        vflag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid_o) vflag = 1'b1;
        end
        check_eq("no_rsp_after_rst", vflag, 0);

        // A following command completes normally.
        ack_at  = 2;
        rd_word = 32'h7777_1111;
        issue(1'b0, 17'h1FFF0, 4'hC, 32'h0, 32'h7777_1111, 1'b0);
        get_rsp(0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
